// File: rtl/background_fetch_datapath.sv
// Background fetch datapath: turns controller strobes into VRAM/attribute reads and a panned pixel stream.
// Optional feature: define BG_FLIP_EN for per-tile horizontal/vertical flip from attribute bits 4/5.
module background_fetch_datapath #(
    parameter int LINE_PIXELS = 320,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lineStarting,
    input  logic [3:0]        panOffset,
    input  logic [5:0]        coarseX,
    input  logic [7:0]        rowY,
    input  logic [ADDR_W-1:0] mapBase,
    input  logic [ADDR_W-1:0] attrBase,
    input  logic [ADDR_W-1:0] tileBase,
    input  logic              charAddrOut,
    input  logic              charDataIn,
    input  logic              palAddrOut,
    input  logic              palDataIn,
    input  logic              tileLowAddrOut,
    input  logic              tileLowDataIn,
    input  logic              tileHighAddrOut,
    input  logic              tileHighDataIn,
    input  logic              pixelOut,
    output logic [ADDR_W-1:0] vramAddr,
    output logic              vramRead,
    input  logic [7:0]        vramData,
    output logic [ADDR_W-1:0] attrAddr,
    output logic              attrRead,
    input  logic [7:0]        attrData,
    output logic [5:0]        pixelColor,
    output logic              pixelValid
);

    localparam int PC_W = $clog2(LINE_PIXELS + 1);

    logic            active;
    logic [2:0]      fine;
    logic [5:0]      tileIdx;
    logic [PC_W-1:0] pixCount;
    logic [7:0]      charLatch, attrLatch, loLatch;
    logic [7:0]      loPlane, hiPlane;
    logic [3:0]      palette;
    logic [2:0]      pixIdx;
    logic            firstTile, tileLoaded, flipReg;

    logic [5:0]        col;
    logic [10:0]       mapOff;
    logic [2:0]        tr;
    logic [ADDR_W-1:0] mapOffExt, tileAddr;
    logic [7:0]        curLo, curHi;
    logic [2:0]        curIdx, bitSel;
    logic [3:0]        curPal;
    logic              curFirst, curFlip, discard;
    logic              unusedBits;

    assign col       = coarseX + tileIdx;
    assign mapOff    = {rowY[7:3], col};
    assign mapOffExt = {{(ADDR_W-11){1'b0}}, mapOff};

`ifdef BG_FLIP_EN
    assign tr         = attrLatch[5] ? ~rowY[2:0] : rowY[2:0];
    assign unusedBits = ^{panOffset[3], attrLatch[7:6]};
`else
    assign tr         = rowY[2:0];
    assign unusedBits = ^{panOffset[3], attrLatch[7:4]};
`endif

    assign tileAddr = tileBase + {{(ADDR_W-12){1'b0}}, charLatch, 4'b0000}
                    + {{(ADDR_W-3){1'b0}}, tr};

    // The first pixel of a tile is taken straight from the bytes being loaded this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        curLo    = loPlane;
        curHi    = hiPlane;
        curIdx   = pixIdx;
        curPal   = palette;
        curFirst = firstTile;
        curFlip  = flipReg;
        if (tileHighDataIn) begin
            curLo    = loLatch;
            curHi    = vramData;
            curIdx   = 3'd0;
            curPal   = attrLatch[3:0];
            curFirst = (tileIdx == 6'd0);
`ifdef BG_FLIP_EN
            curFlip  = attrLatch[4];
`endif
        end
        bitSel  = curFlip ? curIdx : ~curIdx;
        discard = (curFirst && (curIdx < fine)) || (pixCount == PC_W'(LINE_PIXELS));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active     <= 1'b0;
            fine       <= '0;
            tileIdx    <= '0;
            pixCount   <= '0;
            charLatch  <= '0;
            attrLatch  <= '0;
            loLatch    <= '0;
            loPlane    <= '0;
            hiPlane    <= '0;
            palette    <= '0;
            pixIdx     <= '0;
            firstTile  <= 1'b0;
            tileLoaded <= 1'b0;
            flipReg    <= 1'b0;
            vramAddr   <= '0;
            vramRead   <= 1'b0;
            attrAddr   <= '0;
            attrRead   <= 1'b0;
            pixelColor <= '0;
            pixelValid <= 1'b0;
        end else begin
            // NOTE: single-cycle pulses default low here; a later non-blocking assignment in this block wins.
            vramRead   <= 1'b0;
            attrRead   <= 1'b0;
            pixelValid <= 1'b0;
            if (lineStarting) begin
                active     <= 1'b1;
                fine       <= panOffset[2:0];
                tileIdx    <= '0;
                pixCount   <= '0;
                tileLoaded <= 1'b0;
            end else if (active) begin
                if (charAddrOut) begin
                    vramAddr <= mapBase + mapOffExt;
                    vramRead <= 1'b1;
                end else if (tileLowAddrOut) begin
                    vramAddr <= tileAddr;
                    vramRead <= 1'b1;
                end else if (tileHighAddrOut) begin
                    vramAddr <= tileAddr + ADDR_W'(8);
                    vramRead <= 1'b1;
                end
                if (palAddrOut) begin
                    attrAddr <= attrBase + mapOffExt;
                    attrRead <= 1'b1;
                end
                if (charDataIn)    charLatch <= vramData;
                if (palDataIn)     attrLatch <= attrData;
                if (tileLowDataIn) loLatch   <= vramData;
                if (tileHighDataIn) begin
                    loPlane    <= loLatch;
                    hiPlane    <= vramData;
                    palette    <= attrLatch[3:0];
                    firstTile  <= (tileIdx == 6'd0);
                    flipReg    <= curFlip;
                    pixIdx     <= 3'd0;
                    tileIdx    <= tileIdx + 6'd1;
                    tileLoaded <= 1'b1;
                end
                if (pixelOut && (tileHighDataIn || tileLoaded)) begin
                    pixIdx <= curIdx + 3'd1;
                    if (!discard) begin
                        pixelValid <= 1'b1;
                        pixelColor <= {curPal, curHi[bitSel], curLo[bitSel]};
                        pixCount   <= pixCount + PC_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_background_fetch_datapath.sv
// Directed bench for background_fetch_datapath: emulates the strobe controller and both RAMs.
// Expectations for the flip case follow BG_FLIP_EN.
module tb_background_fetch_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        lineStarting;
    logic [3:0]  panOffset;
    logic [5:0]  coarseX;
    logic [7:0]  rowY;
    logic [15:0] mapBase, attrBase, tileBase;
    logic        charAddrOut, charDataIn, palAddrOut, palDataIn;
    logic        tileLowAddrOut, tileLowDataIn, tileHighAddrOut, tileHighDataIn, pixelOut;
    logic [15:0] vramAddr, attrAddr;
    logic        vramRead, attrRead;
    logic [7:0]  vramData, attrData;
    logic [5:0]  pixelColor;
    logic        pixelValid;

    logic [7:0]  vram    [0:65535];
    logic [7:0]  attrMem [0:65535];
    logic [7:0]  tLo [0:63];
    logic [7:0]  tHi [0:63];
    logic [5:0]  pixQ[$];
    logic [15:0] vLog[$];
    logic [15:0] aLog[$];
    int          nAssert = 0;
    int          nFail   = 0;
    int          pixAtReset, vLogAtReset;

    background_fetch_datapath dut (
        .clk(clk), .reset(reset), .lineStarting(lineStarting), .panOffset(panOffset),
        .coarseX(coarseX), .rowY(rowY), .mapBase(mapBase), .attrBase(attrBase),
        .tileBase(tileBase), .charAddrOut(charAddrOut), .charDataIn(charDataIn),
        .palAddrOut(palAddrOut), .palDataIn(palDataIn), .tileLowAddrOut(tileLowAddrOut),
        .tileLowDataIn(tileLowDataIn), .tileHighAddrOut(tileHighAddrOut),
        .tileHighDataIn(tileHighDataIn), .pixelOut(pixelOut), .vramAddr(vramAddr),
        .vramRead(vramRead), .vramData(vramData), .attrAddr(attrAddr), .attrRead(attrRead),
        .attrData(attrData), .pixelColor(pixelColor), .pixelValid(pixelValid)
    );

    always #5 clk = ~clk;

    // RAM models: data appears the cycle after the read enable.
    always @(posedge clk) begin
        if (vramRead) vramData <= vram[vramAddr];
        if (attrRead) attrData <= attrMem[attrAddr];
    end

    always @(posedge clk) begin
        #1;
        if (pixelValid) pixQ.push_back(pixelColor);
        if (vramRead)   vLog.push_back(vramAddr);
        if (attrRead)   aLog.push_back(attrAddr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setTile(input int n, input logic [7:0] lo, input logic [7:0] hi);
        tLo[n] = lo;
        tHi[n] = hi;
        vram[16'h1000 + n*16]     = lo;
        vram[16'h1000 + n*16 + 8] = hi;
    endtask

    // Drives the controller's 12-cycle slot schedule; pixel shifting overlaps the next slot.
    task automatic runLine(input int tiles, input bit doStart, input int resetAtPix);
        int pixRem = 0;
        int resetState = 0;
        if (doStart) begin
            @(negedge clk);
            lineStarting = 1'b1;
        end
        for (int cyc = 0; cyc < tiles*12 + 20; cyc++) begin
            int  c;
            bit  inLine;
            @(negedge clk);
            lineStarting = 1'b0;
            if (resetState == 1) begin
                check("reset_mid_line_outputs", {pixelValid, vramRead, attrRead}, 3'b000);
                reset = 1'b0;
                resetState = 2;
            end
            if (resetAtPix >= 0 && resetState == 0 && pixQ.size() == resetAtPix) begin
                reset = 1'b1;
                resetState = 1;
                pixAtReset = pixQ.size();
                vLogAtReset = vLog.size();
            end
            c      = cyc % 12;
            inLine = (cyc / 12) < tiles;
            charAddrOut     = inLine && c == 0;
            palAddrOut      = inLine && c == 1;
            charDataIn      = inLine && c == 2;
            palDataIn       = inLine && c == 3;
            tileLowAddrOut  = inLine && c == 4;
            tileLowDataIn   = inLine && c == 6;
            tileHighAddrOut = inLine && c == 7;
            tileHighDataIn  = inLine && c == 9;
            if (inLine && c == 9) pixRem = 8;
            pixelOut = pixRem > 0;
            if (pixRem > 0) pixRem--;
        end
        @(negedge clk);
        {charAddrOut, palAddrOut, charDataIn, palDataIn, tileLowAddrOut,
         tileLowDataIn, tileHighAddrOut, tileHighDataIn, pixelOut} = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic checkStream(input string tag, input int f, input logic [3:0] pal);
        int firstBad = -1;
        for (int j = 0; j < 320 && j < pixQ.size(); j++) begin
            int p = j + f;
            int t = p / 8;
            int k = 7 - (p % 8);
            logic [5:0] e = {pal, tHi[t][k], tLo[t][k]};
            if (firstBad < 0 && pixQ[j] !== e) firstBad = j;
        end
        check(tag, firstBad, -1);
    endtask

    task automatic clearLogs();
        pixQ.delete();
        vLog.delete();
        aLog.delete();
    endtask

    initial begin
        reset = 1'b1;
        lineStarting = 1'b0;
        panOffset = '0; coarseX = '0; rowY = '0;
        mapBase = '0; attrBase = '0; tileBase = 16'h1000;
        {charAddrOut, palAddrOut, charDataIn, palDataIn, tileLowAddrOut,
         tileLowDataIn, tileHighAddrOut, tileHighDataIn, pixelOut} = '0;
        for (int a = 0; a < 65536; a++) begin
            vram[a]    = 8'h00;
            attrMem[a] = 8'h00;
        end
        for (int n = 0; n < 64; n++) begin
            vram[n]    = 8'(n);
            attrMem[n] = 8'h05;
            setTile(n, 8'hFF, 8'h00);
        end
        repeat (3) @(negedge clk);
        check("reset_values", {vramAddr, attrAddr, pixelColor, vramRead, attrRead, pixelValid}, '0);
        reset = 1'b0;

        // Strobes before any lineStarting are ignored.
        runLine(2, 1'b0, -1);
        check("idle_pixels", pixQ.size(), 0);
        check("idle_vram_reads", vLog.size(), 0);
        check("idle_attr_reads", aLog.size(), 0);

        // Plain line, no pan.
        clearLogs();
        runLine(41, 1'b1, -1);
        check("t1_pixel_count", pixQ.size(), 320);
        checkStream("t1_stream_0x15", 0, 4'h5);
        check("t1_first_vram_addr", vLog[0], 16'h0000);
        check("t1_first_attr_addr", aLog[0], 16'h0000);
        check("t1_tile0_low_addr", vLog[1], 16'h1000);
        check("t1_tile0_high_addr", vLog[2], 16'h1008);
        check("t1_tile1_low_addr", vLog[4], 16'h1010);
        check("t1_vram_read_pulses", vLog.size(), 123);

        // Fine pan of 3; bit 3 of panOffset has no datapath effect.
        for (int n = 0; n < 64; n++) setTile(n, 8'(n), 8'h00);
        clearLogs();
        panOffset = 4'hB;
        runLine(41, 1'b1, -1);
        check("t2_pixel_count", pixQ.size(), 320);
        check("t2_first_pixel", pixQ[0], 6'h14);
        check("t2_last_pixel", (pixQ.size() > 0) ? pixQ[pixQ.size()-1] : 6'h3F, 6'h15);
        checkStream("t2_stream", 3, 4'h5);

        // Column wrap: map offsets 62, 63, 0, 1 on map row 5.
        clearLogs();
        panOffset = 4'h0; coarseX = 6'd62; rowY = 8'h2D;
        mapBase = 16'h0300; attrBase = 16'h0700;
        runLine(4, 1'b1, -1);
        check("t3_char_addr_62", vLog[0], 16'h047E);
        check("t3_char_addr_63", vLog[3], 16'h047F);
        check("t3_char_addr_0", vLog[6], 16'h0440);
        check("t3_char_addr_1", vLog[9], 16'h0441);
        check("t3_attr_addr_62", aLog[0], 16'h087E);
        check("t3_attr_addr_63", aLog[1], 16'h087F);
        check("t3_attr_addr_0", aLog[2], 16'h0840);
        check("t3_attr_addr_1", aLog[3], 16'h0841);

        // Tile address arithmetic.
        clearLogs();
        coarseX = 6'd0; rowY = 8'd5; mapBase = 16'h0000; attrBase = 16'h0000;
        tileBase = 16'h4000; vram[0] = 8'h12;
        runLine(1, 1'b1, -1);
        check("t4_low_addr", vLog[1], 16'h4125);
        check("t4_high_addr", vLog[2], 16'h412D);

        // Reset at pixCount 100, then strobes with no lineStarting.
        clearLogs();
        vram[0] = 8'h00; rowY = 8'd0; tileBase = 16'h1000;
        for (int n = 0; n < 64; n++) setTile(n, 8'hFF, 8'h00);
        runLine(41, 1'b1, 100);
        check("t5_pixels_after_reset", pixQ.size(), pixAtReset);
        check("t5_reads_after_reset", vLog.size(), vLogAtReset);
        runLine(3, 1'b0, -1);
        check("t5_idle_pixels", pixQ.size(), 100);

        // Reset and lineStarting together: reset wins, block stays idle.
        clearLogs();
        @(negedge clk);
        reset = 1'b1; lineStarting = 1'b1;
        @(negedge clk);
        reset = 1'b0; lineStarting = 1'b0;
        runLine(2, 1'b0, -1);
        check("t7_reset_wins_pixels", pixQ.size(), 0);
        check("t7_reset_wins_reads", vLog.size(), 0);

        // Attribute 0x10 with lo=0x80: flip bit only matters when BG_FLIP_EN is defined.
        clearLogs();
        vram[0] = 8'h30; vram[16'h1300] = 8'h80; vram[16'h1308] = 8'h00; attrMem[0] = 8'h10;
        runLine(1, 1'b1, -1);
        check("t6_pixel_count", pixQ.size(), 8);
`ifdef BG_FLIP_EN
        check("t6_pixel0", pixQ[0], 6'h00);
        check("t6_pixel7", pixQ[7], 6'h01);
`else
        check("t6_pixel0", pixQ[0], 6'h01);
        check("t6_pixel7", pixQ[7], 6'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
